// File: rtl/cell_cfg_loader.sv
// Serial configuration loader for NCELL 4-bit mux-cell truth tables.
// Optional odd-parity word checking is enabled by defining CFG_PARITY_EN.
module cell_cfg_loader #(
  parameter int NCELL = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_valid,
  input  logic [3:0]         cfg_data,
`ifdef CFG_PARITY_EN
  input  logic               cfg_par,
`endif
  output logic               cfg_ready,
  output logic [4*NCELL-1:0] cfg_out,
  output logic               cell_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IW = (NCELL > 1) ? $clog2(NCELL) : 1;

`ifdef CFG_PARITY_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t        state;
  logic [IW-1:0] idx;
  logic          xfer;
  logic          last;

  assign xfer = cfg_valid & cfg_ready;
  assign last = (idx == IW'(NCELL-1));

`ifdef CFG_PARITY_EN
  logic par_ok;
  assign par_ok = ^{cfg_par, cfg_data};
`else
  assign err = 1'b0;
`endif

  // cfg_ready is registered and rises one cycle after entering LOAD, so it
  // never depends combinationally on cfg_valid.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state     <= IDLE;
      idx       <= '0;
      cfg_out   <= '0;
      cell_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b0;
`ifdef CFG_PARITY_EN
      err       <= 1'b0;
`endif
    end else if (state != LOAD) begin
      if (start) begin
        state     <= LOAD;
        idx       <= '0;
        cfg_out   <= '0;
        cell_en   <= 1'b0;
        done      <= 1'b0;
        busy      <= 1'b1;
        cfg_ready <= 1'b0;
`ifdef CFG_PARITY_EN
        err       <= 1'b0;
`endif
      end
    end else if (abort) begin
      state     <= IDLE;
      idx       <= '0;
      cfg_out   <= '0;
      busy      <= 1'b0;
      cfg_ready <= 1'b0;
`ifdef CFG_PARITY_EN
    end else if (xfer && !par_ok) begin
      state     <= ERR;
      err       <= 1'b1;
      busy      <= 1'b0;
      cfg_ready <= 1'b0;
`endif
    end else if (xfer) begin
      cfg_out[4*idx +: 4] <= cfg_data;
      if (last) begin
        state     <= DONE;
        done      <= 1'b1;
        cell_en   <= 1'b1;
        busy      <= 1'b0;
        cfg_ready <= 1'b0;
      end else begin
        idx       <= idx + 1'b1;
      end
    end else begin
      cfg_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cell_cfg_loader.sv
// Scoreboard bench for cell_cfg_loader (NCELL=4); expected configurations are
// built from the word lists and compared by a monitor when done rises.
module tb_cell_cfg_loader;
  localparam int NCELL = 4;
  localparam int W = 4*NCELL;

  logic clk = 1'b0, clr = 1'b0, start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [3:0] cfg_data = 4'h0;
`ifdef CFG_PARITY_EN
  logic cfg_par = 1'b0;
  logic par_bad = 1'b0;
`endif
  logic cfg_ready, cell_en, busy, done, err;
  logic [W-1:0] cfg_out;

  typedef struct {
    logic [W-1:0] cfg;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, start_cyc = 0;
  logic done_prev = 1'b0;

  cell_cfg_loader #(.NCELL(NCELL)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
`ifdef CFG_PARITY_EN
    .cfg_par(cfg_par),
`endif
    .cfg_ready(cfg_ready), .cfg_out(cfg_out), .cell_en(cell_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every completed load must match the oldest expected entry.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending load");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("final_cfg_out", cfg_out, e.cfg);
        chk("final_cell_en", cell_en, 1);
        chk("final_busy", busy, 0);
        if (e.lat >= 0) chk("load_latency", cyc - start_cyc, e.lat);
      end
    end
    done_prev = done;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Presents one word and returns at the negedge after its handshake edge.
  task automatic send(input logic [3:0] w);
    bit hs;
    hs = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = w;
`ifdef CFG_PARITY_EN
    cfg_par   = par_bad ? ^w : ~^w;
`endif
    for (int n = 0; n < 20 && !hs; n++) begin
      hs = cfg_ready;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got no cfg_ready expected handshake for %0h", w);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] ws[NCELL]);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NCELL; i++) r = r | (W'(ws[i]) << (4*i));
    return r;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cfg_out"}, cfg_out, 0);
    chk({nm, "_cfg_ready"}, cfg_ready, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_cell_en"}, cell_en, 0);
    chk({nm, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] ws[NCELL];
    logic [3:0] ref_ws[NCELL];
    int gaps[NCELL];
    int tot;
    exp_t e;
    ref_ws = '{4'h8, 4'h6, 4'h1, 4'hE};

    // reset
    idle(3);
    chk_all_zero("reset");
    clr = 1'b1;
    @(negedge clk);

    // back-to-back load with minimum latency
    e.cfg = pack(ref_ws); e.lat = NCELL + 1;
    chk("model_e168", e.cfg, 16'hE168);
    sbq.push_back(e);
    start_load();
    for (int i = 0; i < NCELL; i++) send(ref_ws[i]);
    idle(2);

    // abort in DONE is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_done_cell_en", cell_en, 1);
    chk("abort_in_done_cfg_out", cfg_out, 16'hE168);
    chk("abort_in_done_done", done, 1);

    // restart from DONE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_cell_en", cell_en, 0);
    chk("restart_cfg_out", cfg_out, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    e.cfg = 16'hFFFF; e.lat = -1;
    sbq.push_back(e);
    for (int i = 0; i < NCELL; i++) send(4'hF);
    idle(2);

    // cfg_valid alternating: one dead cycle after each word but the last
    e.cfg = pack(ref_ws); e.lat = NCELL + 1 + (NCELL - 1);
    sbq.push_back(e);
    start_load();
    for (int i = 0; i < NCELL; i++) begin
      send(ref_ws[i]);
      if (i < NCELL - 1) idle(1);
    end
    idle(2);

    // abort together with the third word
    start_load();
    send(ref_ws[0]);
    send(ref_ws[1]);
    cfg_valid = 1'b1; cfg_data = ref_ws[2]; abort = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cfg_ready", cfg_ready, 0);
    chk("abort_cfg_out", cfg_out, 0);
    chk("abort_done", done, 0);
    idle(3);
    chk("abort_stays_idle_busy", busy, 0);
    chk("abort_stays_idle_cfg_out", cfg_out, 0);

    // clr mid-load overrides start and a transfer
    start_load();
    send(ref_ws[0]);
    clr = 1'b0; start = 1'b1; cfg_valid = 1'b1; cfg_data = 4'h3;
    @(negedge clk);
    chk_all_zero("clr_midload");
    clr = 1'b1; start = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk("clr_then_idle_busy", busy, 0);

    // randomized loads, random gaps, start sometimes held during LOAD
    for (int k = 0; k < 8; k++) begin
      bit hold;
      tot = 0;
      hold = 1'($urandom_range(0, 1));
      for (int i = 0; i < NCELL; i++) begin
        ws[i] = 4'($urandom_range(0, 15));
        gaps[i] = (i < NCELL - 1) ? $urandom_range(0, 2) : 0;
        tot += gaps[i];
      end
      e.cfg = pack(ws); e.lat = NCELL + 1 + tot;
      sbq.push_back(e);
      start_load();
      if (hold) start = 1'b1;
      for (int i = 0; i < NCELL; i++) begin
        if (i == NCELL - 1) start = 1'b0;
        send(ws[i]);
        idle(gaps[i]);
      end
      idle(2);
    end

`ifdef CFG_PARITY_EN
    // parity error on word 2, then recovery via start
    start_load();
    send(4'h8);
    par_bad = 1'b1;
    send(4'h6);
    par_bad = 1'b0;
    chk("par_err", err, 1);
    chk("par_cfg_out", cfg_out, 16'h0008);
    chk("par_cfg_ready", cfg_ready, 0);
    chk("par_cell_en", cell_en, 0);
    chk("par_busy", busy, 0);
    idle(2);
    chk("par_err_held", err, 1);
    start_load();
    chk("par_restart_err", err, 0);
    chk("par_restart_busy", busy, 1);
    e.cfg = pack(ref_ws); e.lat = -1;
    sbq.push_back(e);
    for (int i = 0; i < NCELL; i++) send(ref_ws[i]);
    idle(2);
`endif

    idle(3);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
